tq_row_gather: RTL and testbench



---
 rtl/tq_row_gather.sv | 141 ++++++++++++++
 tb/tb_tq_row_gather.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tq_row_gather.sv
// Row gatherer: collects four-sample beats into a full 32-sample row and presents it,
// with its size and inverse flag, as one wide word to the permutation stage.
module tq_row_gather #(
    parameter int unsigned DW    = 16,
    parameter int unsigned LANES = 4,
    parameter int unsigned NMAX  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [1:0]            i_size,
    input  logic                  i_inverse,
    input  logic [LANES*DW-1:0]   i_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [1:0]            o_size,
    output logic                  o_inverse,
    output logic [NMAX*DW-1:0]    o_data
);

    localparam int unsigned NBEATS = NMAX / LANES;
    localparam int unsigned CW     = $clog2(NBEATS);
    localparam int unsigned RW     = NMAX * DW;

    typedef enum logic [0:0] {StIdle, StCollect} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        size_q, size_d;
    logic              inv_q, inv_d;
    logic [RW-1:0]     buf_q, buf_d;
    logic              out_valid_q, out_valid_d;
    logic [1:0]        out_size_q, out_size_d;
    logic              out_inv_q, out_inv_d;
    logic [RW-1:0]     out_data_q, out_data_d;

    logic [1:0]        eff_size;
    logic              eff_inv;
    logic [CW-1:0]     beat_idx;
    logic [CW-1:0]     last_idx;
    logic              last_beat;
    logic              accept;
    int unsigned       row_len;
    logic [RW-1:0]     merged;
    logic [RW-1:0]     row_out;

    // Size and flag come straight from the input only on the first beat of a row.
    always_comb begin
        eff_size = (state_q == StIdle) ? i_size : size_q;
        eff_inv  = (state_q == StIdle) ? i_inverse : inv_q;
        beat_idx = (state_q == StIdle) ? '0 : cnt_q;
        last_idx = CW'((32'd1 << eff_size) - 32'd1);
        last_beat = (beat_idx == last_idx);
        row_len  = LANES << eff_size;
    end

    // A completing beat must wait only if the output register is still occupied.
    assign i_ready = !(last_beat && out_valid_q && !o_ready);
    assign accept  = i_valid && i_ready;

    always_comb begin
        merged = buf_q;
        for (int unsigned k = 0; k < LANES; k++) begin
            merged[(LANES * 32'(beat_idx) + k) * DW +: DW] = i_data[k * DW +: DW];
        end
    end

    always_comb begin
        row_out = merged;
        for (int unsigned n = 0; n < NMAX; n++) begin
            if (n >= row_len) begin
                row_out[n * DW +: DW] = '0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        inv_d       = inv_q;
        buf_d       = buf_q;
        out_valid_d = out_valid_q;
        out_size_d  = out_size_q;
        out_inv_d   = out_inv_q;
        out_data_d  = out_data_q;

        if (out_valid_q && o_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (last_beat) begin
                out_valid_d = 1'b1;
                out_data_d  = row_out;
                out_size_d  = eff_size;
                out_inv_d   = eff_inv;
                buf_d       = '0;
                cnt_d       = '0;
                state_d     = StIdle;
            end else begin
                buf_d   = merged;
                cnt_d   = beat_idx + CW'(1);
                size_d  = eff_size;
                inv_d   = eff_inv;
                state_d = StCollect;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            size_q      <= '0;
            inv_q       <= 1'b0;
            buf_q       <= '0;
            out_valid_q <= 1'b0;
            out_size_q  <= '0;
            out_inv_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            inv_q       <= inv_d;
            buf_q       <= buf_d;
            out_valid_q <= out_valid_d;
            out_size_q  <= out_size_d;
            out_inv_q   <= out_inv_d;
            out_data_q  <= out_data_d;
        end
    end

    assign o_valid   = out_valid_q;
    assign o_size    = out_size_q;
    assign o_inverse = out_inv_q;
    assign o_data    = out_data_q;

endmodule

// File: tb/tb_tq_row_gather.sv
// Directed bench for tq_row_gather; expected rows are queued when their last beat is sent
// and compared by a monitor when the row is handed downstream.
module tb_tq_row_gather;

    localparam int unsigned DW    = 16;
    localparam int unsigned LANES = 4;
    localparam int unsigned NMAX  = 32;
    localparam int unsigned RW    = NMAX * DW;

    logic                clk = 1'b0;
    logic                rst;
    logic                i_valid;
    logic                i_ready;
    logic [1:0]          i_size;
    logic                i_inverse;
    logic [LANES*DW-1:0] i_data;
    logic                o_valid;
    logic                o_ready;
    logic [1:0]          o_size;
    logic                o_inverse;
    logic [RW-1:0]       o_data;

    tq_row_gather #(.DW(DW), .LANES(LANES), .NMAX(NMAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_size    (i_size),
        .i_inverse (i_inverse),
        .i_data    (i_data),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_size    (o_size),
        .o_inverse (o_inverse),
        .o_data    (o_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] smp [NMAX];
    logic [RW+2:0] exp_q [$];

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] exp_row(input logic [1:0] sz);
        logic [RW-1:0] r;
        r = '0;
        for (int unsigned n = 0; n < (LANES << sz); n++) r[n * DW +: DW] = smp[n];
        return r;
    endfunction

    function automatic logic [LANES*DW-1:0] beat_data(input int unsigned b);
        logic [LANES*DW-1:0] d;
        for (int unsigned k = 0; k < LANES; k++) d[k * DW +: DW] = smp[LANES * b + k];
        return d;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] sz, input logic inv, input logic [LANES*DW-1:0] d,
                        input string tag);
        i_valid   = 1'b1;
        i_size    = sz;
        i_inverse = inv;
        i_data    = d;
        @(negedge clk);
        chk(tag, RW'(i_ready), RW'(1));
        cycle();
        i_valid = 1'b0;
    endtask

    task automatic send_row(input logic [1:0] sz, input logic inv, input int gap,
                            input string tag);
        int unsigned nb;
        nb = 1 << sz;
        for (int unsigned b = 0; b < nb; b++) begin
            beat(sz, inv, beat_data(b), tag);
            if (b == nb - 1) exp_q.push_back({inv, sz, exp_row(sz)});
            else repeat (gap) cycle();
        end
    endtask

    task automatic rand_smp();
        for (int n = 0; n < NMAX; n++) smp[n] = 16'($urandom);
    endtask

    // Output monitor: scoreboard pop on handshake, stability check while stalled.
    logic          prv_hold = 1'b0;
    logic [RW+2:0] prv_out;
    logic [RW+2:0] e;

    always @(negedge clk) begin
        if (!rst) begin
            if (prv_hold) begin
                chk("hold_valid", RW'(o_valid), RW'(1));
                chk("hold_data", o_data, prv_out[RW-1:0]);
                chk("hold_size", RW'(o_size), RW'(prv_out[RW+1:RW]));
                chk("hold_inv", RW'(o_inverse), RW'(prv_out[RW+2]));
            end
            if (o_valid && o_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL spurious_row: observed row %0h required none", o_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("row_data", o_data, e[RW-1:0]);
                    chk("row_size", RW'(o_size), RW'(e[RW+1:RW]));
                    chk("row_inv", RW'(o_inverse), RW'(e[RW+2]));
                end
            end
        end
        prv_hold <= !rst && o_valid && !o_ready;
        prv_out  <= {o_inverse, o_size, o_data};
    end

    logic [RW-1:0] exp_a;
    logic [RW-1:0] exp_b;
    logic [RW-1:0] exp_nogap;

    initial begin
        rst       = 1'b1;
        i_valid   = 1'b0;
        i_size    = 2'b00;
        i_inverse = 1'b0;
        i_data    = '0;
        o_ready   = 1'b1;
        repeat (2) cycle();
        chk("rst_valid", RW'(o_valid), RW'(0));
        chk("rst_data", o_data, '0);
        chk("rst_size", RW'(o_size), RW'(0));
        chk("rst_inv", RW'(o_inverse), RW'(0));
        rst = 1'b0;
        #1;
        chk("idle_ready", RW'(i_ready), RW'(1));

        // Size 32 forward, value n at element n.
        for (int n = 0; n < NMAX; n++) smp[n] = 16'(n);
        send_row(2'b11, 1'b0, 0, "s32_acc");
        chk("s32_valid", RW'(o_valid), RW'(1));
        cycle();
        chk("s32_pulse", RW'(o_valid), RW'(0));

        // Size 4 inverse, signed samples, repeated back to back.
        for (int n = 0; n < NMAX; n++) smp[n] = 16'hA5A5;
        smp[0] = 16'sd1;
        smp[1] = -16'sd2;
        smp[2] = 16'sd3;
        smp[3] = -16'sd4;
        for (int r = 0; r < 3; r++) begin
            send_row(2'b00, 1'b1, 0, "s4_acc");
            chk("s4_valid", RW'(o_valid), RW'(1));
        end
        cycle();
        chk("s4_drop", RW'(o_valid), RW'(0));

        // Backpressure, size 8.
        o_ready = 1'b0;
        rand_smp();
        exp_a = exp_row(2'b01);
        send_row(2'b01, 1'b0, 0, "bp_a_acc");
        chk("bp_a_valid", RW'(o_valid), RW'(1));
        rand_smp();
        exp_b = exp_row(2'b01);
        beat(2'b01, 1'b1, beat_data(0), "bp_b0_acc");
        i_valid   = 1'b1;
        i_size    = 2'b11;
        i_inverse = 1'b0;
        i_data    = beat_data(1);
        @(negedge clk);
        chk("bp_stall", RW'(i_ready), RW'(0));
        chk("bp_hold_a", o_data, exp_a);
        cycle();
        o_ready = 1'b1;
        exp_q.push_back({1'b1, 2'b01, exp_b});
        @(negedge clk);
        chk("bp_release", RW'(i_ready), RW'(1));
        cycle();
        o_ready = 1'b0;
        i_valid = 1'b0;
        chk("bp_b_valid", RW'(o_valid), RW'(1));
        chk("bp_b_data", o_data, exp_b);
        cycle();
        o_ready = 1'b1;
        cycle();
        cycle();
        chk("bp_drop", RW'(o_valid), RW'(0));

        // First-beat size/flag win over later beats.
        rand_smp();
        beat(2'b10, 1'b0, beat_data(0), "mid_acc");
        for (int unsigned b = 1; b < 4; b++) beat(2'b00, 1'b1, beat_data(b), "mid_acc");
        exp_q.push_back({1'b0, 2'b10, exp_row(2'b10)});
        chk("mid_valid", RW'(o_valid), RW'(1));
        cycle();

        // Reset in the middle of a size-32 row.
        rand_smp();
        for (int unsigned b = 0; b < 3; b++) beat(2'b11, 1'b1, beat_data(b), "rst_mid_acc");
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_mid_valid", RW'(o_valid), RW'(0));
        chk("rst_mid_data", o_data, '0);
        rand_smp();
        send_row(2'b01, 1'b0, 0, "post_rst_acc");
        chk("post_rst_data", o_data, exp_row(2'b01));
        cycle();

        // Size 16 without and with idle gaps.
        rand_smp();
        exp_nogap = exp_row(2'b10);
        send_row(2'b10, 1'b0, 0, "s16_acc");
        cycle();
        send_row(2'b10, 1'b0, 2, "gap_acc");
        chk("gap_valid", RW'(o_valid), RW'(1));
        chk("gap_data", o_data, exp_nogap);
        cycle();
        chk("gap_drop", RW'(o_valid), RW'(0));

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
        chk("drain", RW'(exp_q.size()), RW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
